gol_gen_scheduler: RTL and testbench

- Sequencing controller for the Game of Life board engine.
- Turns debounced single-cycle button pulses and a 2-bit speed select into clear, load and step commands for the board datapath.
- Steps are issued over a req/done handshake; the block tracks the 16-bit generation count that feeds the display path.
- Sits between the button/switch conditioning logic and the board update engine inside the machine top.

---
 rtl/gol_gen_scheduler_if.sv | 28 ++
 rtl/gol_gen_scheduler.sv | 100 ++++++++++
 tb/tb_gol_gen_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gol_gen_scheduler_if.sv
// Command/status bundle between the button conditioning logic, the generation
// scheduler and the board update engine.
interface gol_gen_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             start_pulse;
  logic             step_pulse;
  logic             clear_pulse;
  logic             load_pulse;
  logic [1:0]       speed;
  logic             step_done;
  logic             step_req;
  logic             clear_req;
  logic             load_req;
  logic [CNT_W-1:0] gen_cnt;
  logic             running;
  logic             busy;

  modport master (
    output start_pulse, step_pulse, clear_pulse, load_pulse, speed, step_done,
    input  step_req, clear_req, load_req, gen_cnt, running, busy
  );

  modport slave (
    input  start_pulse, step_pulse, clear_pulse, load_pulse, speed, step_done,
    output step_req, clear_req, load_req, gen_cnt, running, busy
  );
endinterface

// File: rtl/gol_gen_scheduler.sv
// Run/pause/step sequencer for the Game of Life engine: paces step requests
// from a speed-selected divider and counts committed generations.
module gol_gen_scheduler #(
  parameter int unsigned BASE_DIV = 1000000,
  parameter int unsigned CNT_W    = 16
) (
  input logic                clk,
  input logic                reset,
  gol_gen_scheduler_if.slave bus
);
  localparam int unsigned DIV_W = $clog2(BASE_DIV * 8);

  typedef enum logic [1:0] {PAUSE, RUN, BUSY} state_t;

  state_t           state, state_n;
  state_t           ret, ret_n;
  logic [DIV_W-1:0] div, div_n, last;
  logic [CNT_W-1:0] gen_n;
  logic             clear_n, load_n;

  // Terminal divider value follows speed combinationally, so a speed change
  // to a shorter period fires on the next edge if the count is already past it.
  always_comb begin
    case (bus.speed)
      2'd3:    last = DIV_W'(BASE_DIV - 1);
      2'd2:    last = DIV_W'(BASE_DIV * 2 - 1);
      2'd1:    last = DIV_W'(BASE_DIV * 4 - 1);
      default: last = DIV_W'(BASE_DIV * 8 - 1);
    endcase
  end

  always_comb begin
    state_n = state;
    ret_n   = ret;
    div_n   = div;
    gen_n   = bus.gen_cnt;
    clear_n = 1'b0;
    load_n  = 1'b0;
    case (state)
      PAUSE: begin
        if (bus.clear_pulse) begin
          clear_n = 1'b1;
          gen_n   = '0;
        end else if (bus.load_pulse) begin
          load_n = 1'b1;
        end else if (bus.start_pulse) begin
          state_n = RUN;
          div_n   = '0;
        end else if (bus.step_pulse) begin
          state_n = BUSY;
          ret_n   = PAUSE;
        end
      end
      RUN: begin
        if (bus.start_pulse) begin
          state_n = PAUSE;
        end else if (div >= last) begin
          state_n = BUSY;
          ret_n   = RUN;
        end else begin
          div_n = div + 1'b1;
        end
      end
      BUSY: begin
        // Toggle first so a coincident done lands in the newly chosen state.
        if (bus.start_pulse) ret_n = (ret == RUN) ? PAUSE : RUN;
        if (bus.step_done) begin
          gen_n   = bus.gen_cnt + 1'b1;
          state_n = ret_n;
          div_n   = '0;
        end
      end
      default: state_n = PAUSE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PAUSE;
      ret           <= PAUSE;
      div           <= '0;
      bus.step_req  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.clear_req <= 1'b0;
      bus.load_req  <= 1'b0;
      bus.gen_cnt   <= '0;
      bus.running   <= 1'b0;
    end else begin
      state         <= state_n;
      ret           <= ret_n;
      div           <= div_n;
      bus.step_req  <= (state_n == BUSY);
      bus.busy      <= (state_n == BUSY);
      bus.clear_req <= clear_n;
      bus.load_req  <= load_n;
      bus.gen_cnt   <= gen_n;
      bus.running   <= (state_n == RUN) || (state_n == BUSY && ret_n == RUN);
    end
  end
endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Scoreboard bench for gol_gen_scheduler: stimulus queues expected clear/load/
// generation events, a negedge monitor pops and compares them as they appear.
module tb_gol_gen_scheduler;
  localparam int unsigned BASE_DIV = 4;
  localparam int unsigned CNT_W    = 12;
  localparam int unsigned MOD      = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gol_gen_scheduler_if #(.CNT_W(CNT_W)) bus ();

  gol_gen_scheduler #(.BASE_DIV(BASE_DIV), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {EV_CLEAR, EV_LOAD, EV_GEN} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    int unsigned cnt;
  } ev_t;

  ev_t         expq[$];
  int          total = 0;
  int          bad = 0;
  int unsigned model_gen = 0;

  function automatic void check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int unsigned period(input logic [1:0] s);
    return BASE_DIV * (1 << (3 - int'(s)));
  endfunction

  function automatic void push_ev(input ev_kind_t k, input int unsigned c);
    ev_t e;
    e.kind = k;
    e.cnt  = c;
    expq.push_back(e);
  endfunction

  task automatic pop_cmp(input ev_kind_t k, input string name);
    ev_t e;
    if (expq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event with gen_cnt=%0d, expected no event", name, bus.gen_cnt);
    end else begin
      e = expq.pop_front();
      check({name, "_kind"}, k, e.kind);
      check({name, "_value"}, bus.gen_cnt, e.cnt);
    end
  endtask

  // Monitor: outputs at a negedge reflect the preceding posedge; rst_d holds
  // the reset level that posedge sampled.
  initial begin
    bit          rst_d;
    int unsigned last_gen;
    rst_d    = 1'b1;
    last_gen = 0;
    forever begin
      @(negedge clk);
      if (rst_d) begin
        last_gen = bus.gen_cnt;
      end else begin
        if (bus.clear_req) pop_cmp(EV_CLEAR, "clear_ev");
        if (bus.load_req) pop_cmp(EV_LOAD, "load_ev");
        if (!bus.clear_req && bus.gen_cnt != last_gen) pop_cmp(EV_GEN, "gen_ev");
        last_gen = bus.gen_cnt;
      end
      rst_d = reset;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit c, input bit l, input bit s, input bit st);
    bus.clear_pulse = c;
    bus.load_pulse  = l;
    bus.step_pulse  = s;
    bus.start_pulse = st;
    tick();
    bus.clear_pulse = 1'b0;
    bus.load_pulse  = 1'b0;
    bus.step_pulse  = 1'b0;
    bus.start_pulse = 1'b0;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!bus.step_req && n < 2000) begin
      tick();
      n++;
    end
    if (!bus.step_req) begin
      total++;
      bad++;
      $display("FAIL wait_req: timeout step_req=0 expected 1");
    end
  endtask

  // Hold off done for lat cycles with step_req high, then answer for one cycle.
  task automatic answer(input int unsigned lat);
    int unsigned hi;
    hi = 0;
    model_gen = (model_gen + 1) % MOD;
    push_ev(EV_GEN, model_gen);
    for (int unsigned i = 0; i < lat; i++) begin
      tick();
      if (bus.step_req) hi++;
    end
    check("req_held", hi, lat);
    bus.step_done = 1'b1;
    tick();
    bus.step_done = 1'b0;
    check("req_drop", bus.step_req, 0);
    check("busy_drop", bus.busy, 0);
    check("gen_after_done", bus.gen_cnt, model_gen);
  endtask

  task automatic count_req(input int unsigned cycles, output int unsigned seen);
    seen = 0;
    for (int unsigned i = 0; i < cycles; i++) begin
      tick();
      if (bus.step_req) seen++;
    end
  endtask

  task automatic do_clear();
    model_gen = 0;
    push_ev(EV_CLEAR, 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int          n;
    int unsigned seen;
    int unsigned r, k;
    bit          c, l, s;
    logic [1:0]  spd;

    bus.start_pulse = 1'b0;
    bus.step_pulse  = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.load_pulse  = 1'b0;
    bus.step_done   = 1'b0;
    bus.speed       = 2'd3;
    reset           = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_step_req", bus.step_req, 0);
    check("rst_clear_req", bus.clear_req, 0);
    check("rst_load_req", bus.load_req, 0);
    check("rst_gen_cnt", bus.gen_cnt, 0);
    check("rst_running", bus.running, 0);
    check("rst_busy", bus.busy, 0);

    // Single step from pause, done two cycles after req
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("step_lat1", bus.step_req, 1);
    check("step_busy", bus.busy, 1);
    check("step_running", bus.running, 0);
    answer(2);
    check("step_gen1", bus.gen_cnt, 1);
    count_req(10, seen);
    check("step_back_pause", seen, 0);

    // Run at speed 3, five generations
    do_clear();
    tick();
    check("clear_one_cycle", bus.clear_req, 0);
    bus.speed = 2'd3;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("run_running", bus.running, 1);
    for (int unsigned g = 0; g < 5; g++) begin
      wait_req(n);
      check("run_req_lat", n, period(2'd3));
      check("run_running_busy", bus.running, 1);
      answer(1);
      check("run_running_after", bus.running, 1);
    end
    check("run_gen5", bus.gen_cnt, 5);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("pause_running", bus.running, 0);

    // Slowest speed spacing, then a speed change mid-count
    bus.speed = 2'd0;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    wait_req(n);
    check("slow_first_lat", n, period(2'd0));
    answer(0);
    wait_req(n);
    check("slow_spacing", n, period(2'd0));
    answer(0);
    repeat (10) tick();
    check("slow_no_req_yet", bus.step_req, 0);
    bus.speed = 2'd3;
    tick();
    check("speed_change_fire", bus.step_req, 1);
    answer(0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("slow_paused", bus.running, 0);

    // Pause requested while a step is outstanding
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    wait_req(n);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("busy_pause_running", bus.running, 0);
    check("busy_pause_req_kept", bus.step_req, 1);
    answer(1);
    check("busy_pause_running_after", bus.running, 0);
    count_req(100, seen);
    check("busy_pause_no_req", seen, 0);

    // Pause and done on the same edge
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    wait_req(n);
    model_gen = (model_gen + 1) % MOD;
    push_ev(EV_GEN, model_gen);
    bus.start_pulse = 1'b1;
    bus.step_done   = 1'b1;
    tick();
    bus.start_pulse = 1'b0;
    bus.step_done   = 1'b0;
    check("same_edge_running", bus.running, 0);
    check("same_edge_req", bus.step_req, 0);
    count_req(3 * period(2'd3), seen);
    check("same_edge_paused", seen, 0);

    // Priority in pause, pulses ignored in run, done ignored outside busy
    model_gen = 0;
    push_ev(EV_CLEAR, 0);
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    check("prio_load", bus.load_req, 0);
    check("prio_step", bus.step_req, 0);
    tick();
    check("prio_clear_drop", bus.clear_req, 0);
    check("prio_step_later", bus.step_req, 0);
    push_ev(EV_LOAD, model_gen);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("load_one_cycle", bus.load_req, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    check("run_clear_ignored", bus.clear_req, 0);
    check("run_load_ignored", bus.load_req, 0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("run_clear_paused", bus.running, 0);
    bus.step_done = 1'b1;
    tick();
    bus.step_done = 1'b0;
    check("stray_done", bus.gen_cnt, model_gen);

    // Randomized mix
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        c = 1'($urandom_range(0, 1));
        l = 1'($urandom_range(0, 1));
        s = 1'($urandom_range(0, 1));
        if (c) begin
          model_gen = 0;
          push_ev(EV_CLEAR, 0);
        end else if (l) begin
          push_ev(EV_LOAD, model_gen);
        end
        pulse(c, l, s, 1'b0);
        if (!c && !l && s) begin
          check("rnd_step_req", bus.step_req, 1);
          answer($urandom_range(0, 3));
        end else begin
          check("rnd_no_step", bus.step_req, 0);
          tick();
        end
      end else if (r == 1) begin
        spd = 2'($urandom_range(0, 3));
        bus.speed = spd;
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        k = $urandom_range(1, 3);
        for (int unsigned g = 0; g < k; g++) begin
          wait_req(n);
          check("rnd_run_lat", n, period(spd));
          answer($urandom_range(0, 3));
        end
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("rnd_run_pause", bus.running, 0);
      end else begin
        bus.speed = 2'($urandom_range(2, 3));
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        wait_req(n);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("rnd_busy_pause", bus.running, 0);
        answer($urandom_range(0, 2));
        count_req(20, seen);
        check("rnd_busy_paused", seen, 0);
      end
    end

    // Counter wrap
    do_clear();
    for (int unsigned i = 0; i < MOD - 1; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      answer(0);
    end
    check("wrap_max", bus.gen_cnt, MOD - 1);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    answer(0);
    check("wrap_zero", bus.gen_cnt, 0);

    // Reset while a step is outstanding
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_busy_req", bus.step_req, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_gen = 0;
    check("rst_mid_req", bus.step_req, 0);
    check("rst_mid_busy", bus.busy, 0);
    bus.step_done = 1'b1;
    tick();
    bus.step_done = 1'b0;
    check("rst_late_done", bus.gen_cnt, 0);
    tick();
    check("rst_late_req", bus.step_req, 0);

    repeat (3) tick();
    check("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
